// File: rtl/shift_ctrl.sv
// LED rotator control: prescaled one-cycle shift strobe plus shift direction, taken from a
// debounced push-button toggle or, in ping-pong mode, from the rotator's end bits.
module shift_ctrl #(
    parameter int unsigned N_LEDS     = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned LIM0       = 2**22 - 1,
    parameter int unsigned LIM1       = 2**23 - 1,
    parameter int unsigned LIM2       = 2**24 - 1,
    parameter int unsigned LIM3       = 2**25 - 1,
    parameter int unsigned DEB_CYCLES = 2**20
) (
    input  logic              clk,
    input  logic              i_ck_rst,
    input  logic              i_run,
    input  logic [1:0]        i_speed_sel,
    input  logic              i_btn_dir,
    input  logic              i_pingpong,
    input  logic [N_LEDS-1:0] i_shiftreg,
    output logic              o_shift_enable,
    output logic              o_shift_dir
);

    localparam int unsigned      DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic {
        StIzq = 1'b0,
        StDer = 1'b1
    } dir_e;

    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] cnt_q;
    logic             en_q;

    logic             sync1_q, sync2_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic             deb_q, deb_prev_q;
    logic             toggle;

    dir_e             state_q, state_d;
    logic             at_right, at_left;

    always_comb begin
        lim = CNT_W'(LIM0);
        case (i_speed_sel)
            2'd0:    lim = CNT_W'(LIM0);
            2'd1:    lim = CNT_W'(LIM1);
            2'd2:    lim = CNT_W'(LIM2);
            default: lim = CNT_W'(LIM3);
        endcase
    end

    // '>=' rather than '==' so switching to a smaller limit wraps immediately.
    always_ff @(posedge clk) begin
        if (i_ck_rst) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else if (i_run) begin
            if (cnt_q >= lim) begin
                cnt_q <= '0;
                en_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                en_q  <= 1'b0;
            end
        end else begin
            en_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_ck_rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_cnt_q  <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
        end else begin
            sync1_q    <= i_btn_dir;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            if (sync2_q == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                deb_q     <= sync2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + DEB_W'(1);
            end
        end
    end

    assign toggle   = deb_q & ~deb_prev_q;
    assign at_right = i_shiftreg[0];
    assign at_left  = i_shiftreg[N_LEDS-1];

    // Both ends lit or neither lit holds direction so the bounce cannot oscillate.
    always_comb begin
        state_d = state_q;
        if (i_pingpong) begin
            if (state_q == StDer) begin
                if (at_right && !at_left) state_d = StIzq;
            end else begin
                if (at_left && !at_right) state_d = StDer;
            end
        end else if (toggle) begin
            state_d = (state_q == StDer) ? StIzq : StDer;
        end
    end

    always_ff @(posedge clk) begin
        if (i_ck_rst) state_q <= StDer;
        else          state_q <= state_d;
    end

    assign o_shift_enable = en_q;
    assign o_shift_dir    = (state_q == StDer);

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl: prescaler rates, button debounce/toggle, ping-pong bounce
// against a rotating-register model, and synchronous reset.
module tb_shift_ctrl;

    logic       clk;
    logic       rst;
    logic       run;
    logic [1:0] sel;
    logic       btn;
    logic       pp;
    logic [3:0] sr;
    logic [3:0] sr_init;
    logic       sr_load;
    logic       model_en;
    logic       en;
    logic       dir;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] EXP_SR  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                          4'b0100, 4'b0010, 4'b0001, 4'b0010};
    localparam logic       EXP_DIR [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    shift_ctrl #(
        .N_LEDS     (4),
        .CNT_W      (32),
        .LIM0       (3),
        .LIM1       (7),
        .LIM2       (1),
        .LIM3       (15),
        .DEB_CYCLES (4)
    ) dut (
        .clk            (clk),
        .i_ck_rst       (rst),
        .i_run          (run),
        .i_speed_sel    (sel),
        .i_btn_dir      (btn),
        .i_pingpong     (pp),
        .i_shiftreg     (sr),
        .o_shift_enable (en),
        .o_shift_dir    (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rotator model: rotates on each strobe, so any wrap-around would show up.
    always @(posedge clk) begin
        if (sr_load) sr <= sr_init;
        else if (model_en && en) sr <= dir ? {sr[0], sr[3:1]} : {sr[2:0], sr[3]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic load_sr(input logic [3:0] v);
        sr_init = v;
        sr_load = 1'b1;
        step();
        sr_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; sel = 2'd0; btn = 1'b0; pp = 1'b0;
        sr_init = 4'b0000; sr_load = 1'b1; model_en = 1'b0;

        // 1: reset state, then LIM0=3 gives a strobe every 4 cycles
        step();
        step();
        check("rst_en", {3'b0, en}, 4'd0);
        check("rst_dir", {3'b0, dir}, 4'd1);
        rst = 1'b0;
        sr_load = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("sel0_en_c%0d", i), {3'b0, en}, {3'b0, (i % 4 == 0)});
            check($sformatf("sel0_dir_c%0d", i), {3'b0, dir}, 4'd1);
        end

        // 2: slow rate to cnt=10, then LIM2=1 wraps next cycle; run=0 freezes
        sel = 2'd3;
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("sel3_en_c%0d", i), {3'b0, en}, 4'd0);
        end
        sel = 2'd2;
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("sel2_en_c%0d", i), {3'b0, en}, {3'b0, (i % 2 == 1)});
        end
        run = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("hold_en_c%0d", i), {3'b0, en}, 4'd0);
        end
        run = 1'b1;
        step(); check("resume_en_1", {3'b0, en}, 4'd1);
        step(); check("resume_en_2", {3'b0, en}, 4'd0);
        step(); check("resume_en_3", {3'b0, en}, 4'd1);

        // 3: button toggle, held press flips once, bounce ignored
        run = 1'b0;
        step();
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("press1_dir_c%0d", i), {3'b0, dir}, {3'b0, (i < 7)});
        end
        btn = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("release1_dir_c%0d", i), {3'b0, dir}, 4'd0);
        end
        for (int i = 1; i <= 12; i++) begin
            btn = (i % 2 == 1);
            step();
            check($sformatf("bounce_dir_c%0d", i), {3'b0, dir}, 4'd0);
        end
        btn = 1'b0;
        for (int i = 0; i < 6; i++) step();
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("press2_dir_c%0d", i), {3'b0, dir}, {3'b0, (i >= 7)});
        end
        btn = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("release2_dir_c%0d", i), {3'b0, dir}, 4'd1);
        end

        // 4: ping-pong against the rotator model, starting 0010 going DER
        load_sr(4'b0010);
        pp = 1'b1;
        sel = 2'd0;
        model_en = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 12 && !en; i++) step();
            check($sformatf("pp_strobe_%0d", k), {3'b0, en}, 4'd1);
            step();
            check($sformatf("pp_sr_%0d", k), sr, EXP_SR[k]);
            step();
            check($sformatf("pp_dir_%0d", k), {3'b0, dir}, {3'b0, EXP_DIR[k]});
        end

        // 5: both ends lit holds; rotator reset value 0011 turns DER into IZQ
        model_en = 1'b0;
        run = 1'b0;
        load_sr(4'b1000);
        step();
        check("pp_left_end_dir", {3'b0, dir}, 4'd1);
        load_sr(4'b1001);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("pp_both_ends_dir_c%0d", i), {3'b0, dir}, 4'd1);
        end
        load_sr(4'b0011);
        check("pp_0011_before", {3'b0, dir}, 4'd1);
        step();
        check("pp_0011_after", {3'b0, dir}, 4'd0);

        // 6: leaving ping-pong keeps IZQ; reset mid-count and mid-debounce
        pp = 1'b0;
        load_sr(4'b0000);
        check("leave_pp_dir", {3'b0, dir}, 4'd0);
        sel = 2'd1;
        run = 1'b1;
        for (int i = 0; i < 3; i++) step();
        btn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        check("midrst_en", {3'b0, en}, 4'd0);
        check("midrst_dir", {3'b0, dir}, 4'd1);
        rst = 1'b0;
        btn = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("postrst_en_c%0d", i), {3'b0, en}, {3'b0, (i == 8)});
            check($sformatf("postrst_dir_c%0d", i), {3'b0, dir}, 4'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
